// File: rtl/nor3_seq_pkg.sv
// Shared types and helpers for the NOR3 pattern sequencer: FSM states, pattern
// count and the golden NOR3 response.
package nor3_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NUM_PATTERNS = 8;
    localparam logic [2:0] LAST_PATTERN = 3'(NUM_PATTERNS - 1);

    function automatic logic nor3_expected(input logic [2:0] pattern);
        return ~|pattern;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts the cycles a stimulus pattern is held; last marks the final cycle of
// each dwell, after which the count wraps back to zero.
module dwell_timer #(
    parameter int DWELL = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DWELL - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= last ? '0 : count + CW'(1);
        end
    end

    assign last = (count == LAST_COUNT);

endmodule

// File: rtl/nor3_pattern_sequencer.sv
// Drives A/B/C through all eight patterns, samples the NOR gate's D/E at the
// end of each dwell and accumulates per-pattern results and an error count.
module nor3_pattern_sequencer
    import nor3_seq_pkg::*;
#(
    parameter int DWELL = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    input  logic        D,
    input  logic        E,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_count,
    output logic [15:0] results,
    output logic [1:0]  dbg_state
);

    // Handshake: start is a single-cycle request, accepted only when busy=0
    // (IDLE or DONE); busy covers exactly the 8*DWELL drive cycles, and done
    // rises on the edge busy falls and stays high until the next accepted start.

    state_e     state;
    logic [2:0] pattern;
    logic       dwell_last;
    logic       exp_bit;
    logic       mismatch;
    logic [3:0] err_next;

    dwell_timer #(
        .DWELL(DWELL)
    ) u_dwell_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state != DRIVE),
        .enable(state == DRIVE),
        .last  (dwell_last)
    );

    assign exp_bit  = nor3_expected(pattern);
    assign mismatch = (D != exp_bit) || (E != exp_bit);
    assign err_next = err_count + {3'b000, mismatch};

    // pattern is held at zero outside DRIVE, so the stimulus pins rest at 000.
    assign {A, B, C} = pattern;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pattern   <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            results   <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DRIVE;
                        pattern   <= 3'd0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= 4'd0;
                        results   <= 16'd0;
                    end
                end
                DRIVE: begin
                    if (dwell_last) begin
                        results[{pattern, 1'b0} +: 2] <= {D, E};
                        err_count <= err_next;
                        if (pattern == LAST_PATTERN) begin
                            state   <= DONE;
                            pattern <= 3'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            // Include the final pattern's verdict in pass.
                            pass    <= (err_next == 4'd0);
                        end else begin
                            pattern <= pattern + 3'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    pattern <= 3'd0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nor3_pattern_sequencer.sv
// Self-checking bench for nor3_pattern_sequencer: a faultable NOR3 gate model
// feeds D/E, a reference model predicts each run, a monitor checks the outputs.
module tb_nor3_pattern_sequencer;

    localparam int DWELL      = 4;
    localparam int RUN_CYCLES = 8 * DWELL;
    localparam int W          = 21;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        A, B, C, D, E;
    logic        busy, done, pass;
    logic [3:0]  err_count;
    logic [15:0] results;
    logic [1:0]  dbg_state;
    logic [2:0]  abc;

    logic [7:0]  d_flip = 8'h00;
    logic [7:0]  e_flip = 8'h00;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_start_cyc = 0;
    bit run_live = 1'b0;

    logic [W-1:0] exp_q[$];

    nor3_pattern_sequencer #(
        .DWELL(DWELL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .E        (E),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .results  (results),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign abc = {A, B, C};

    // Gate under test: ideal NOR3, with optional per-pattern output inversions.
    always_comb begin
        D = 1'b0;
        E = 1'b0;
        D = (abc == 3'b000) ^ d_flip[abc];
        E = (abc == 3'b000) ^ e_flip[abc];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {results, err_count, pass} from the pattern rules, independent of timing.
    function automatic logic [W-1:0] model(input logic [7:0] dm, input logic [7:0] em);
        logic [15:0] r;
        int          e;
        logic        want, d_v, e_v;
        r = 16'd0;
        e = 0;
        for (int p = 0; p < 8; p++) begin
            want = (p == 0);
            d_v  = want ^ dm[p];
            e_v  = want ^ em[p];
            r[2*p+1] = d_v;
            r[2*p]   = e_v;
            if (d_v != want || e_v != want) e++;
        end
        return {r, 4'(e), (e == 0)};
    endfunction

    // Monitor: per-cycle sequencing checks and scoreboard pop on completion.
    always @(negedge clk) begin
        int k;
        logic [W-1:0] exp_v;
        if (run_live) begin
            k = cyc - run_start_cyc;
            if (k == 0) begin
                check("cleared_results", results, 16'd0);
                check("cleared_err", err_count, 4'd0);
                check("cleared_pass", pass, 1'b0);
                check("done_low_in_run", done, 1'b0);
            end
            if (k < RUN_CYCLES) begin
                check("busy_in_run", busy, 1'b1);
                check("pattern_abc", abc, k / DWELL);
            end else begin
                check("done_at_end", done, 1'b1);
                check("busy_at_end", busy, 1'b0);
                check("abc_at_end", abc, 3'b000);
                check("state_done", dbg_state, 2'd2);
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("results", results, exp_v[20:5]);
                    check("err_count", err_count, exp_v[4:1]);
                    check("pass", pass, exp_v[0]);
                end
                run_live = 1'b0;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_abc"}, abc, 3'b000);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_err"}, err_count, 4'd0);
        check({tag, "_results"}, results, 16'd0);
        check({tag, "_state"}, dbg_state, 2'd0);
    endtask

    task automatic do_run(input logic [7:0] dm, input logic [7:0] em,
                          input bit pulse_mid, input bit abort);
        int k;
        @(negedge clk);
        d_flip = dm;
        e_flip = em;
        exp_q.push_back(model(dm, em));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_start_cyc = cyc;
        run_live = 1'b1;
        for (int i = 0; i < RUN_CYCLES + 20 && run_live; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            k = cyc - run_start_cyc;
            if (pulse_mid && k == 10) start = 1'b1;
            if (abort && k == 21) begin
                run_live = 1'b0;
                reset = 1'b1;
                start = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                start = 1'b0;
                check_reset_state("abort");
                void'(exp_q.pop_back());
                return;
            end
        end
        check("run_timeout", run_live, 1'b0);
        if (run_live) begin
            run_live = 1'b0;
            void'(exp_q.pop_back());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] dm, em;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("idle");

        do_run(8'h00, 8'h00, 1'b0, 1'b0);
        do_run(8'h01, 8'h00, 1'b0, 1'b0);
        do_run(8'h00, 8'hFF, 1'b0, 1'b0);
        do_run(8'h00, 8'h00, 1'b1, 1'b0);
        do_run(8'h00, 8'h00, 1'b0, 1'b1);
        do_run(8'h00, 8'h00, 1'b0, 1'b0);
        do_run(8'h00, 8'h00, 1'b0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            dm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            em = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            do_run(dm, em, ($urandom_range(0, 3) == 0), 1'b0);
        end

        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
